// File: rtl/fpu_seq_pkg.sv
// fpu_seq_pkg: sequencer state type, fpusel codes and the fixed FPU latency table
package fpu_seq_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} fpu_seq_state_t;

    localparam logic [4:0] SEL_ADD    = 5'd0,
                           SEL_SUB    = 5'd1,
                           SEL_MUL    = 5'd2,
                           SEL_DIV    = 5'd3,
                           SEL_SQRT   = 5'd4,
                           SEL_MIN    = 5'd5,
                           SEL_MAX    = 5'd6,
                           SEL_CMP    = 5'd7,
                           SEL_SGNJ   = 5'd8,
                           SEL_CVT    = 5'd9,
                           SEL_MV     = 5'd10,
                           SEL_CLASS  = 5'd11,
                           SEL_FMADD  = 5'd12,
                           SEL_FMSUB  = 5'd13,
                           SEL_FNMSUB = 5'd14,
                           SEL_FNMADD = 5'd15;

    function automatic logic fpu_legal(input logic [4:0] sel);
        return sel <= SEL_FNMADD;
    endfunction

    // Illegal selects map to 1 so callers never load an out-of-range count
    function automatic logic [4:0] fpu_lat(input logic [4:0] sel);
        return (sel inside {SEL_ADD, SEL_SUB})                       ? 5'd3  :
               (sel == SEL_MUL)                                      ? 5'd4  :
               (sel == SEL_DIV)                                      ? 5'd12 :
               (sel == SEL_SQRT)                                     ? 5'd14 :
               (sel inside {SEL_FMADD, SEL_FMSUB, SEL_FNMSUB, SEL_FNMADD}) ? 5'd5 :
               (sel inside {SEL_MIN, SEL_MAX, SEL_CMP, SEL_SGNJ,
                            SEL_CVT, SEL_MV, SEL_CLASS})             ? 5'd1  : 5'd1;
    endfunction

endpackage

// File: rtl/fpu_sequencer.sv
// fpu_sequencer: one-at-a-time FP issue controller; launches the FPU, stalls the pipe for
// the op's fixed latency, captures the result and hands it to EX/MEM.
module fpu_sequencer
    import fpu_seq_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 4
) (
    input  logic            clk,
    input  logic            Rst,
    input  logic            issue_valid,
    input  logic            flush,
    input  logic            mem_hold,
    input  logic [4:0]      ID_EX_fpusel,
    input  logic [2:0]      ID_EX_frm,
    input  logic [XLEN-1:0] ID_EX_dout_rs1,
    input  logic [XLEN-1:0] ID_EX_dout_rs2,
    input  logic [XLEN-1:0] ID_EX_dout_rs3,
    output logic            fpu_start,
    output logic [XLEN-1:0] fpu_a,
    output logic [XLEN-1:0] fpu_b,
    output logic [XLEN-1:0] fpu_c,
    output logic [4:0]      fpu_sel,
    output logic [2:0]      fpu_rm,
    input  logic [XLEN-1:0] fpu_res,
    input  logic [4:0]      fpu_flags,
    output logic            f_stall,
    output logic [XLEN-1:0] fp_res,
    output logic [4:0]      fp_flags,
    output logic            fp_res_valid,
    output logic            illegal_op
);

    fpu_seq_state_t   r_state, w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [XLEN-1:0]  r_a, r_b, r_c, r_res;
    logic [4:0]       r_sel, r_flags;
    logic [2:0]       r_rm;
    logic             w_legal, w_issue, w_cap;

    assign w_legal = fpu_legal(ID_EX_fpusel);

    // Rst gates the combinational outputs so they read 0 while reset is held
    always_comb begin
        w_next     = r_state;
        w_issue    = 1'b0;
        w_cap      = 1'b0;
        illegal_op = 1'b0;
        case (r_state)
            IDLE: begin
                w_issue    = Rst & issue_valid & w_legal & ~flush;
                illegal_op = Rst & issue_valid & ~w_legal;
                w_next     = w_issue ? BUSY : IDLE;
            end
            BUSY: begin
                w_cap  = ~flush & (r_cnt == '0);
                w_next = flush ? IDLE : (r_cnt == '0) ? DONE : BUSY;
            end
            DONE:    w_next = (flush | ~mem_hold) ? IDLE : DONE;
            default: w_next = IDLE;
        endcase
    end

    assign fpu_start    = w_issue;
    assign f_stall      = w_issue | (r_state == BUSY);
    assign fp_res_valid = (r_state == DONE);
    assign fpu_a        = r_a;
    assign fpu_b        = r_b;
    assign fpu_c        = r_c;
    assign fpu_sel      = r_sel;
    assign fpu_rm       = r_rm;
    assign fp_res       = r_res;
    assign fp_flags     = r_flags;

    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_c     <= '0;
            r_sel   <= '0;
            r_rm    <= '0;
            r_res   <= '0;
            r_flags <= '0;
        end else begin
            if (w_issue) begin
                r_cnt <= CNT_W'(fpu_lat(ID_EX_fpusel) - 5'd1);
                r_a   <= ID_EX_dout_rs1;
                r_b   <= ID_EX_dout_rs2;
                r_c   <= ID_EX_dout_rs3;
                r_sel <= ID_EX_fpusel;
                r_rm  <= ID_EX_frm;
            end else if (r_state == BUSY && r_cnt != '0) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if (w_cap) begin
                r_res   <= fpu_res;
                r_flags <= fpu_flags;
            end
        end
    end

endmodule

// File: tb/tb_fpu_sequencer.sv
// tb_fpu_sequencer: table-driven check of issue/stall/capture timing against hand-computed latencies
module tb_fpu_sequencer;
    import fpu_seq_pkg::*;

    typedef struct packed {
        logic [4:0]  sel;
        logic [2:0]  rm;
        logic [31:0] a, b, c, res;
        logic [4:0]  flg;
        logic [4:0]  lat;   // 0 marks an illegal select
    } vec_t;

    logic        clk = 1'b0;
    logic        Rst, issue_valid, flush, mem_hold;
    logic [4:0]  ID_EX_fpusel, fpu_sel, fpu_flags, fp_flags;
    logic [2:0]  ID_EX_frm, fpu_rm;
    logic [31:0] ID_EX_dout_rs1, ID_EX_dout_rs2, ID_EX_dout_rs3;
    logic [31:0] fpu_a, fpu_b, fpu_c, fpu_res, fp_res;
    logic        fpu_start, f_stall, fp_res_valid, illegal_op;

    int   errors = 0;
    int   checks = 0;
    vec_t vecs[12];

    fpu_sequencer #(.XLEN(32), .CNT_W(4)) dut (
        .clk(clk), .Rst(Rst), .issue_valid(issue_valid), .flush(flush), .mem_hold(mem_hold),
        .ID_EX_fpusel(ID_EX_fpusel), .ID_EX_frm(ID_EX_frm),
        .ID_EX_dout_rs1(ID_EX_dout_rs1), .ID_EX_dout_rs2(ID_EX_dout_rs2), .ID_EX_dout_rs3(ID_EX_dout_rs3),
        .fpu_start(fpu_start), .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_c(fpu_c),
        .fpu_sel(fpu_sel), .fpu_rm(fpu_rm), .fpu_res(fpu_res), .fpu_flags(fpu_flags),
        .f_stall(f_stall), .fp_res(fp_res), .fp_flags(fp_flags),
        .fp_res_valid(fp_res_valid), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, exp);
        end
    endtask

    function automatic vec_t mk(input logic [4:0] sel, input logic [2:0] rm, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] c, input logic [31:0] res,
                                input logic [4:0] flg, input logic [4:0] lat);
        return '{sel, rm, a, b, c, res, flg, lat};
    endfunction

    // Called #1 after a rising edge; that cycle is cycle 0 (issue). hold = mem_hold cycles in DONE
    // (mem_hold is also raised in cycle 0 to show it does not block issue); fk = flush cycle or -1.
    // The stand-in FPU presents the result only in cycle L and junk everywhere else.
    task automatic run_op(input vec_t v, input int hold, input int fk);
        int L, eb, ve, lk, n;
        logic acc;
        logic [31:0] em_st, em_go, em_v, em_il, am_st, am_go, am_v, am_il, pa;
        L   = int'(v.lat);
        acc = (L != 0) && (fk != 0);
        eb  = (acc && fk > 0 && fk <= L) ? fk : L;
        ve  = (!acc || (fk > 0 && fk <= L)) ? -1 : (fk > L) ? fk : L + 1 + hold;
        lk  = !acc ? 0 : (ve >= 0) ? ve : eb;
        n   = lk + 3;
        pa  = fpu_a;
        {em_st, em_go, em_v, em_il, am_st, am_go, am_v, am_il} = '0;
        for (int k = 0; k < n; k++) begin
            issue_valid    = (k <= lk);
            flush          = (k == fk);
            mem_hold       = (hold > 0) && (k == 0 || (k > L && k <= L + hold));
            ID_EX_fpusel   = (k == 0) ? v.sel : 5'd2;
            ID_EX_frm      = (k == 0) ? v.rm : 3'd7;
            ID_EX_dout_rs1 = (k == 0) ? v.a : ~v.a;
            ID_EX_dout_rs2 = (k == 0) ? v.b : ~v.b;
            ID_EX_dout_rs3 = (k == 0) ? v.c : ~v.c;
            fpu_res        = (k == L) ? v.res : 32'hDEADBEEF;
            fpu_flags      = (k == L) ? v.flg : 5'h1F;
            @(negedge clk);
            em_st[k] = acc && k <= eb;
            em_go[k] = acc && k == 0;
            em_v[k]  = ve >= 0 && k >= L + 1 && k <= ve;
            em_il[k] = L == 0 && k == 0;
            am_st[k] = f_stall;
            am_go[k] = fpu_start;
            am_v[k]  = fp_res_valid;
            am_il[k] = illegal_op;
            if (em_v[k] && (k == L + 1 || k == ve)) begin
                chk("fp_res", fp_res, v.res);
                chk("fp_flags", {27'd0, fp_flags}, {27'd0, v.flg});
            end
            @(posedge clk);
            #1;
        end
        {issue_valid, flush, mem_hold} = 3'b000;
        chk("stall_mask", am_st, em_st);
        chk("start_mask", am_go, em_go);
        chk("valid_mask", am_v, em_v);
        chk("illegal_mask", am_il, em_il);
        if (acc) begin
            chk("fpu_a", fpu_a, v.a);
            chk("fpu_b", fpu_b, v.b);
            chk("fpu_c", fpu_c, v.c);
            chk("fpu_sel_rm", {24'd0, fpu_sel, fpu_rm}, {24'd0, v.sel, v.rm});
        end else begin
            chk("fpu_a_kept", fpu_a, pa);
        end
    endtask

    initial begin
        vecs[0]  = mk(5'd0,  3'd0, 32'h408ccccd, 32'h400ccccd, 32'h0,        32'h40d33333, 5'h01, 5'd3);
        vecs[1]  = mk(5'd1,  3'd1, 32'h40400000, 32'h3f800000, 32'h0,        32'h40000000, 5'h00, 5'd3);
        vecs[2]  = mk(5'd2,  3'd2, 32'h40000000, 32'h40400000, 32'h0,        32'h40c00000, 5'h00, 5'd4);
        vecs[3]  = mk(5'd3,  3'd0, 32'h3f800000, 32'h40400000, 32'h0,        32'h3eaaaaab, 5'h01, 5'd12);
        vecs[4]  = mk(5'd4,  3'd3, 32'h40800000, 32'h0,        32'h0,        32'h40000000, 5'h00, 5'd14);
        vecs[5]  = mk(5'd5,  3'd0, 32'hbf800000, 32'h3f800000, 32'h0,        32'hbf800000, 5'h00, 5'd1);
        vecs[6]  = mk(5'd11, 3'd0, 32'h3f800000, 32'h0,        32'h0,        32'h00000040, 5'h00, 5'd1);
        vecs[7]  = mk(5'd12, 3'd4, 32'h40000000, 32'h40400000, 32'h3f800000, 32'h40e00000, 5'h00, 5'd5);
        vecs[8]  = mk(5'd15, 3'd0, 32'h3f800000, 32'h3f800000, 32'h3f800000, 32'hc0000000, 5'h00, 5'd5);
        vecs[9]  = mk(5'd16, 3'd0, 32'h11111111, 32'h0,        32'h0,        32'h0,        5'h00, 5'd0);
        vecs[10] = mk(5'd20, 3'd0, 32'h22222222, 32'h0,        32'h0,        32'h0,        5'h00, 5'd0);
        vecs[11] = mk(5'd31, 3'd0, 32'h33333333, 32'h0,        32'h0,        32'h0,        5'h00, 5'd0);

        Rst = 1'b0; issue_valid = 1'b1; flush = 1'b0; mem_hold = 1'b0;
        ID_EX_fpusel = 5'd0; ID_EX_frm = 3'd0;
        ID_EX_dout_rs1 = 32'h408ccccd; ID_EX_dout_rs2 = 32'h400ccccd; ID_EX_dout_rs3 = 32'h0;
        fpu_res = 32'hDEADBEEF; fpu_flags = 5'h1F;
        repeat (3) @(negedge clk);
        chk("rst_stall", {31'd0, f_stall}, 32'd0);
        chk("rst_start", {31'd0, fpu_start}, 32'd0);
        chk("rst_valid", {31'd0, fp_res_valid}, 32'd0);
        chk("rst_illegal", {31'd0, illegal_op}, 32'd0);
        chk("rst_fp_res", fp_res, 32'd0);
        chk("rst_fpu_a", fpu_a, 32'd0);
        chk("rst_sel_rm_flags", {19'd0, fpu_sel, fpu_rm, fp_flags}, 32'd0);
        @(posedge clk); #1;
        issue_valid = 1'b0; Rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) run_op(vecs[i], 0, -1);

        run_op(vecs[3], 2, -1);   // div held two cycles in DONE
        run_op(vecs[4], 0, 9);    // sqrt flushed in BUSY when cnt==5
        run_op(vecs[0], 0, -1);   // add afterwards completes normally
        run_op(vecs[2], 3, 6);    // mul held in DONE, then flushed there
        run_op(vecs[1], 0, 0);    // flush coincident with issue
        run_op(vecs[7], 0, 5);    // flush in the capture cycle

        // async reset in the middle of a div
        ID_EX_fpusel = 5'd3; ID_EX_frm = 3'd1; issue_valid = 1'b1;
        ID_EX_dout_rs1 = 32'h3f800000; ID_EX_dout_rs2 = 32'h40400000; ID_EX_dout_rs3 = 32'h0;
        repeat (5) begin @(posedge clk); #1; end
        chk("pre_rst_stall", {31'd0, f_stall}, 32'd1);
        #2 Rst = 1'b0;
        #1;
        chk("arst_stall", {31'd0, f_stall}, 32'd0);
        chk("arst_valid_start", {30'd0, fp_res_valid, fpu_start}, 32'd0);
        chk("arst_fp_res", fp_res, 32'd0);
        chk("arst_fpu_a", fpu_a, 32'd0);
        chk("arst_sel_rm_flags", {19'd0, fpu_sel, fpu_rm, fp_flags}, 32'd0);
        @(posedge clk); #1;
        issue_valid = 1'b0; Rst = 1'b1;
        @(posedge clk); #1;
        run_op(vecs[2], 0, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
